gb_serial: RTL and testbench

- Bus responder for the Game Boy serial link port: SB (serial data, 0xFF01) and SC (serial control, 0xFF02).
- Sits on the core's shared address/data bus beside the HRAM, WRAM and timer responders.
- Shifts a byte out and in over a 3-wire link (clock, out, in), using either an internal divided clock or an external one.
- Raises int_serial when a byte transfer completes.

---
 rtl/gb_serial.sv | 134 +++++++++++++
 tb/tb_gb_serial.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gb_serial.sv
// Game Boy serial link port: SB/SC bus registers and the byte shifter.
// Internal mode drives sclk_out from a divider; external mode follows a
// synchronised sclk_in. int_serial pulses once when eight bits have moved.
module gb_serial #(
  parameter int          CLK_DIV = 512,
  parameter logic [15:0] SB_ADDR = 16'hFF01,
  parameter logic [15:0] SC_ADDR = 16'hFF02
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] db_address,
  inout  wire  [7:0]  db_data,
  input  logic        db_nread,
  input  logic        db_nwrite,
  input  logic        sclk_in,
  input  logic        sin,
  output logic        sclk_out,
  output logic        sout,
  output logic        int_serial,
  output logic        tx_strobe
);

  localparam int            DW   = $clog2(CLK_DIV);
  localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2 - 1);  // last low-phase count
  localparam logic [DW-1:0] MID  = DW'(CLK_DIV / 2);      // first high-phase count
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, EXT} state_t;

  state_t        state, state_nx;
  logic [7:0]    sb;
  logic          clksel;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] div;
  logic          nwrite_q;
  logic          sync1, sync2, sync3;

  logic wr_stb, sb_wr, sc_wr, active;
  logic ext_rise, ext_fall, shift_now, last_bit;

  // One write per strobe: only the falling edge of db_nwrite counts.
  assign wr_stb    = ~db_nwrite & nwrite_q;
  assign sb_wr     = wr_stb & (db_address == SB_ADDR);
  assign sc_wr     = wr_stb & (db_address == SC_ADDR);
  assign active    = (state != IDLE);
  assign ext_rise  = sync2 & ~sync3;
  assign ext_fall  = ~sync2 & sync3;
  // Internal shift happens in the first cycle of the high half.
  assign shift_now = ((state == HIGH) && (div == MID)) || ((state == EXT) && ext_rise);
  assign last_bit  = shift_now && (bit_cnt == 3'd7);

  // Combinational read port; bus is released unless this block is addressed.
  assign db_data = (!db_nread && db_address == SB_ADDR) ? sb :
                   (!db_nread && db_address == SC_ADDR) ? {active, 6'b111111, clksel} :
                   8'hzz;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: an SC write overrides whatever the shifter was about to do.
  always_comb begin
    state_nx = state;
    if (sc_wr) begin
      if (db_data[7]) state_nx = db_data[0] ? LOW : EXT;
      else            state_nx = IDLE;
    end else begin
      case (state)
        LOW:     if (div == HALF) state_nx = HIGH;
        HIGH:    if (last_bit) state_nx = IDLE;
                 else if (div == LAST) state_nx = LOW;
        EXT:     if (last_bit) state_nx = IDLE;
        default: state_nx = state;
      endcase
    end
  end

  // Serial clock is low only during the internal low half.
  always_comb begin
    sclk_out = (state != LOW);
  end

  // Registers, shifter, divider, synchroniser and event pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      sb         <= 8'h00;
      clksel     <= 1'b0;
      bit_cnt    <= 3'd0;
      div        <= '0;
      nwrite_q   <= 1'b1;
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      sync3      <= 1'b1;
      sout       <= 1'b1;
      int_serial <= 1'b0;
      tx_strobe  <= 1'b0;
    end else begin
      nwrite_q   <= db_nwrite;
      sync1      <= sclk_in;
      sync2      <= sync1;
      sync3      <= sync2;
      int_serial <= 1'b0;
      tx_strobe  <= 1'b0;
      if (sc_wr) begin
        clksel <= db_data[0];
        if (db_data[7]) begin
          bit_cnt   <= 3'd0;
          div       <= '0;
          tx_strobe <= 1'b1;
          // Internal mode presents the first bit together with the falling clock.
          sout      <= db_data[0] ? sb[7] : 1'b1;
        end else begin
          sout <= 1'b1;
        end
      end else begin
        if (sb_wr && !active) sb <= db_data;
        if (state == LOW || state == HIGH) div <= (div == LAST) ? '0 : div + DW'(1);
        if (shift_now) begin
          sb      <= {sb[6:0], sin};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            int_serial <= 1'b1;
            sout       <= 1'b1;
          end
        end
        // Next bit goes out as the clock falls (internal wrap or external edge).
        if ((state == HIGH && div == LAST) || (state == EXT && ext_fall)) sout <= sb[7];
      end
    end
  end

endmodule

// File: tb/tb_gb_serial.sv
// Directed bench for gb_serial with a short serial bit period.
module tb_gb_serial;

  localparam int          CLK_DIV = 4;
  localparam logic [15:0] SB = 16'hFF01;
  localparam logic [15:0] SC = 16'hFF02;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] db_address = 16'h0000;
  wire  [7:0]  db_data;
  logic        db_nread = 1'b1, db_nwrite = 1'b1;
  logic        sclk_in = 1'b1, sin_drv = 1'b1, loop_en = 1'b0;
  logic        drv_en = 1'b0;
  logic [7:0]  drv_val = 8'h00;
  logic        sclk_out, sout, int_serial, tx_strobe;
  wire         sin;

  int n_tests = 0, n_fail = 0;
  int int_cnt = 0, tx_cnt = 0, sclk_low_cnt = 0;

  assign sin     = loop_en ? sout : sin_drv;
  assign db_data = drv_en ? drv_val : 8'hzz;

  // Pull-ups make an undriven bus read as 0xFF.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (db_data[i]);
  end

  gb_serial #(.CLK_DIV(CLK_DIV)) dut (
    .clock(clock), .reset(reset), .db_address(db_address), .db_data(db_data),
    .db_nread(db_nread), .db_nwrite(db_nwrite), .sclk_in(sclk_in), .sin(sin),
    .sclk_out(sclk_out), .sout(sout), .int_serial(int_serial), .tx_strobe(tx_strobe)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (int_serial) int_cnt <= int_cnt + 1;
    if (tx_strobe)  tx_cnt  <= tx_cnt + 1;
    if (!sclk_out)  sclk_low_cnt <= sclk_low_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d, input int hold = 1);
    @(negedge clock);
    db_address = a; drv_val = d; drv_en = 1'b1; db_nwrite = 1'b0;
    repeat (hold) @(negedge clock);
    db_nwrite = 1'b1; drv_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
    db_address = a; db_nread = 1'b0;
    #1 d = db_data;
    db_nread = 1'b1;
    #1;
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;   // write data, or expected read data
  } vec_t;

  vec_t       tbl[10];
  logic [7:0] rd, pat;
  int         i0, x0, s0;

  initial begin
    tbl[0] = '{1'b0, SB,       8'h00};
    tbl[1] = '{1'b0, SC,       8'h7E};
    tbl[2] = '{1'b0, 16'hFF03, 8'hFF};
    tbl[3] = '{1'b1, SB,       8'hA5};
    tbl[4] = '{1'b0, SB,       8'hA5};
    tbl[5] = '{1'b1, SC,       8'h01};
    tbl[6] = '{1'b0, SC,       8'h7F};
    tbl[7] = '{1'b1, SC,       8'h00};
    tbl[8] = '{1'b0, SC,       8'h7E};
    tbl[9] = '{1'b0, 16'hFF00, 8'hFF};

    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_sclk", sclk_out, 1);
    check("rst_sout", sout, 1);
    check("rst_int", int_serial, 0);
    check("rst_tx", tx_strobe, 0);

    for (int k = 0; k < 10; k++) begin
      if (tbl[k].wr) bus_wr(tbl[k].addr, tbl[k].data);
      else begin
        bus_rd(tbl[k].addr, rd);
        check($sformatf("vec%0d_rd", k), rd, tbl[k].data);
      end
    end

    // Internal transfer of 0xA5, sin held high.
    pat = 8'hA5;
    sin_drv = 1'b1;
    bus_wr(SC, 8'h81);
    for (int t = 0; t < 40; t++) begin
      if (t < 32) begin
        check($sformatf("int_sclk_t%0d", t), sclk_out, ((t % 4) < 2) ? 0 : 1);
        if ((t % 4) < 2) check($sformatf("int_sout_t%0d", t), sout, pat[7 - t / 4]);
      end else begin
        check($sformatf("int_idle_t%0d", t), {sclk_out, sout}, 2'b11);
      end
      check($sformatf("int_irq_t%0d", t), int_serial, (t == 31) ? 1 : 0);
      check($sformatf("int_tx_t%0d", t), tx_strobe, (t == 0) ? 1 : 0);
      @(negedge clock);
    end
    bus_rd(SB, rd); check("int_sb", rd, 8'hFF);
    bus_rd(SC, rd); check("int_sc", rd, 8'h7F);

    // Loopback returns the original byte.
    bus_wr(SB, 8'h3C);
    loop_en = 1'b1;
    i0 = int_cnt; x0 = tx_cnt;
    bus_wr(SC, 8'h81);
    repeat (40) @(negedge clock);
    loop_en = 1'b0;
    bus_rd(SB, rd); check("loop_sb", rd, 8'h3C);
    check("loop_irq_cnt", int_cnt - i0, 1);
    check("loop_tx_cnt", tx_cnt - x0, 1);

    // External clock: waits forever without edges, then receives 0x5A.
    s0 = sclk_low_cnt;
    bus_wr(SC, 8'h80);
    repeat (50) @(negedge clock);
    bus_rd(SC, rd); check("ext_wait_sc", rd, 8'hFE);
    i0 = int_cnt;
    pat = 8'h5A;
    for (int b = 7; b >= 0; b--) begin
      sclk_in = 1'b0; sin_drv = pat[b];
      repeat (5) @(negedge clock);
      sclk_in = 1'b1;
      repeat (5) @(negedge clock);
    end
    repeat (5) @(negedge clock);
    sin_drv = 1'b1;
    bus_rd(SB, rd); check("ext_sb", rd, 8'h5A);
    bus_rd(SC, rd); check("ext_sc", rd, 8'h7E);
    check("ext_irq_cnt", int_cnt - i0, 1);
    check("ext_sclk_low", sclk_low_cnt - s0, 0);

    // SB write ignored while busy, then abort after 3 bits.
    bus_wr(SB, 8'hA5);
    bus_wr(SC, 8'h81);
    repeat (4) @(negedge clock);
    bus_wr(SB, 8'h00);
    bus_rd(SB, rd); check("busy_sb_ignored", rd, 8'h4B);
    repeat (6) @(negedge clock);
    i0 = int_cnt;
    bus_wr(SC, 8'h01);
    check("abort_sclk", sclk_out, 1);
    check("abort_sout", sout, 1);
    bus_rd(SB, rd); check("abort_sb", rd, 8'h2F);
    bus_rd(SC, rd); check("abort_sc", rd, 8'h7F);
    repeat (64) @(negedge clock);
    check("abort_irq_cnt", int_cnt - i0, 0);

    // Held write strobe starts exactly one transfer.
    bus_wr(SB, 8'h96);
    i0 = int_cnt; x0 = tx_cnt;
    bus_wr(SC, 8'h81, 5);
    repeat (26) @(negedge clock);
    check("hold_irq_t30", int_serial, 0);
    @(negedge clock);
    check("hold_irq_t31", int_serial, 1);
    @(negedge clock);
    check("hold_irq_t32", int_serial, 0);
    repeat (4) @(negedge clock);
    check("hold_tx_cnt", tx_cnt - x0, 1);
    check("hold_irq_cnt", int_cnt - i0, 1);
    bus_rd(SB, rd); check("hold_sb", rd, 8'hFF);

    // Reset during bit 4 aborts without an interrupt.
    bus_wr(SB, 8'h00);
    i0 = int_cnt;
    bus_wr(SC, 8'h81);
    repeat (17) @(negedge clock);
    check("pre_rst_sclk", sclk_out, 0);
    check("pre_rst_sout", sout, 0);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_sclk", sclk_out, 1);
    check("mid_rst_sout", sout, 1);
    check("mid_rst_int", int_serial, 0);
    check("mid_rst_tx", tx_strobe, 0);
    bus_rd(SB, rd); check("mid_rst_sb", rd, 8'h00);
    bus_rd(SC, rd); check("mid_rst_sc", rd, 8'h7E);
    reset = 1'b0;
    repeat (64) @(negedge clock);
    check("mid_rst_irq_cnt", int_cnt - i0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
